// File: rtl/axi_slice_pkg.sv
// Shared types and constants for the AXI4 register slice.
package axi_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS,
    SLICE_FWD,
    SLICE_HALF,
    SLICE_FULL
  } slice_mode_e;

  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_RESP_W = 2;

endpackage

// File: rtl/axi_slice_chan.sv
// One generic valid/ready channel stage: bypass, forward register, half-rate register or
// two-entry skid buffer, selected by MODE.
module axi_slice_chan
  import axi_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             reg_ready, reg_valid, push, pop;

  localparam logic IsBypass = (MODE == SLICE_BYPASS);

  always_comb begin
    reg_valid = (state_q != StEmpty);
    unique case (MODE)
      SLICE_FWD:  reg_ready = (state_q == StEmpty) || out_ready_i;
      SLICE_HALF: reg_ready = (state_q == StEmpty);
      default:    reg_ready = (state_q != StTwo);
    endcase
    // Bypass keeps the storage idle so it folds away.
    push = !IsBypass && in_valid_i && reg_ready;
    pop  = !IsBypass && reg_valid && out_ready_i;
  end

  // head_q always holds the oldest entry; skid_q only fills in the two-entry state.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          head_d  = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          skid_d  = in_data_i;
          state_d = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    if (IsBypass) begin
      in_ready_o  = out_ready_i;
      out_valid_o = in_valid_i;
      out_data_o  = in_data_i;
    end else begin
      in_ready_o  = reg_ready;
      out_valid_o = reg_valid;
      out_data_o  = head_q;
    end
  end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: five independent channel stages between the master-facing s_axi
// port and the slave-facing m_axi port. Packing and instantiation only.
module axi_reg_slice
  import axi_slice_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1,
  parameter slice_mode_e AW_MODE    = SLICE_FULL,
  parameter slice_mode_e W_MODE     = SLICE_FULL,
  parameter slice_mode_e B_MODE     = SLICE_FWD,
  parameter slice_mode_e AR_MODE    = SLICE_FULL,
  parameter slice_mode_e R_MODE     = SLICE_FULL
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // master-facing
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]    s_axi_awlen,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [AXI_RESP_W-1:0]   s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]    s_axi_arlen,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser,
  output logic [AXI_RESP_W-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // slave-facing
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic [USER_WIDTH-1:0]   m_axi_wuser,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_RESP_W-1:0]   m_axi_bresp,
  input  logic [USER_WIDTH-1:0]   m_axi_buser,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [AXI_LEN_W-1:0]    m_axi_arlen,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                    m_axi_rlast,
  input  logic [USER_WIDTH-1:0]   m_axi_ruser,
  input  logic [AXI_RESP_W-1:0]   m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int unsigned AwW = ADDR_WIDTH + AXI_LEN_W;
  localparam int unsigned WW  = DATA_WIDTH * 9 / 8 + 1 + USER_WIDTH;
  localparam int unsigned BW  = AXI_RESP_W + USER_WIDTH;
  localparam int unsigned RW  = DATA_WIDTH + 1 + USER_WIDTH + AXI_RESP_W;

  logic [AwW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [WW-1:0]  w_in, w_out;
  logic [BW-1:0]  b_in, b_out;
  logic [RW-1:0]  r_in, r_out;

  assign aw_in = {s_axi_awaddr, s_axi_awlen};
  assign {m_axi_awaddr, m_axi_awlen} = aw_out;
  assign w_in = {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser} = w_out;
  assign b_in = {m_axi_bresp, m_axi_buser};
  assign {s_axi_bresp, s_axi_buser} = b_out;
  assign ar_in = {s_axi_araddr, s_axi_arlen};
  assign {m_axi_araddr, m_axi_arlen} = ar_out;
  assign r_in = {m_axi_rdata, m_axi_rlast, m_axi_ruser, m_axi_rresp};
  assign {s_axi_rdata, s_axi_rlast, s_axi_ruser, s_axi_rresp} = r_out;

  axi_slice_chan #(.WIDTH(AwW), .MODE(AW_MODE)) u_aw (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .in_valid_i (s_axi_awvalid),
    .in_ready_o (s_axi_awready),
    .in_data_i  (aw_in),
    .out_valid_o(m_axi_awvalid),
    .out_ready_i(m_axi_awready),
    .out_data_o (aw_out)
  );

  axi_slice_chan #(.WIDTH(WW), .MODE(W_MODE)) u_w (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .in_valid_i (s_axi_wvalid),
    .in_ready_o (s_axi_wready),
    .in_data_i  (w_in),
    .out_valid_o(m_axi_wvalid),
    .out_ready_i(m_axi_wready),
    .out_data_o (w_out)
  );

  axi_slice_chan #(.WIDTH(BW), .MODE(B_MODE)) u_b (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .in_valid_i (m_axi_bvalid),
    .in_ready_o (m_axi_bready),
    .in_data_i  (b_in),
    .out_valid_o(s_axi_bvalid),
    .out_ready_i(s_axi_bready),
    .out_data_o (b_out)
  );

  axi_slice_chan #(.WIDTH(AwW), .MODE(AR_MODE)) u_ar (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .in_valid_i (s_axi_arvalid),
    .in_ready_o (s_axi_arready),
    .in_data_i  (ar_in),
    .out_valid_o(m_axi_arvalid),
    .out_ready_i(m_axi_arready),
    .out_data_o (ar_out)
  );

  axi_slice_chan #(.WIDTH(RW), .MODE(R_MODE)) u_r (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .in_valid_i (m_axi_rvalid),
    .in_ready_o (m_axi_rready),
    .in_data_i  (r_in),
    .out_valid_o(s_axi_rvalid),
    .out_ready_i(s_axi_rready),
    .out_data_o (r_out)
  );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: one registered instance (FULL/FULL/FWD/FULL/HALF) checked against
// an occupancy+queue model, plus an all-bypass instance sharing the same inputs.
module tb_axi_reg_slice;
  import axi_slice_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int UW = 1;
  localparam slice_mode_e AwM = SLICE_FULL;
  localparam slice_mode_e WM  = SLICE_FULL;
  localparam slice_mode_e BM  = SLICE_FWD;
  localparam slice_mode_e ArM = SLICE_FULL;
  localparam slice_mode_e RM  = SLICE_HALF;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  // shared stimulus
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0]    s_awlen, s_arlen;
  logic          s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic [DW-1:0] s_wdata, m_rdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wlast, m_rlast;
  logic [UW-1:0] s_wuser, m_buser, m_ruser;
  logic [1:0]    m_bresp, m_rresp;
  logic          m_awready, m_wready, m_arready, m_bvalid, m_rvalid;

  // registered instance outputs
  logic          s_awready, s_wready, s_arready, s_bvalid, s_rvalid, m_bready, m_rready;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0]    m_awlen, m_arlen;
  logic          m_awvalid, m_wvalid, m_arvalid, m_wlast, s_rlast;
  logic [DW-1:0] m_wdata, s_rdata;
  logic [SW-1:0] m_wstrb;
  logic [UW-1:0] m_wuser, s_buser, s_ruser;
  logic [1:0]    s_bresp, s_rresp;

  // bypass instance outputs
  logic          y_s_awready, y_s_wready, y_s_arready, y_s_bvalid, y_s_rvalid;
  logic          y_m_bready, y_m_rready;
  logic [AW-1:0] y_m_awaddr, y_m_araddr;
  logic [7:0]    y_m_awlen, y_m_arlen;
  logic          y_m_awvalid, y_m_wvalid, y_m_arvalid, y_m_wlast, y_s_rlast;
  logic [DW-1:0] y_m_wdata, y_s_rdata;
  logic [SW-1:0] y_m_wstrb;
  logic [UW-1:0] y_m_wuser, y_s_buser, y_s_ruser;
  logic [1:0]    y_s_bresp, y_s_rresp;

  int n_checks = 0;
  int n_fail = 0;

  axi_reg_slice #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
    .AW_MODE(AwM), .W_MODE(WM), .B_MODE(BM), .AR_MODE(ArM), .R_MODE(RM)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awvalid(s_awvalid),
    .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
    .s_axi_wuser(s_wuser), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_buser(s_buser), .s_axi_bvalid(s_bvalid),
    .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arvalid(s_arvalid),
    .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rlast(s_rlast), .s_axi_ruser(s_ruser),
    .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_wuser(m_wuser), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_buser(m_buser), .m_axi_bvalid(m_bvalid),
    .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arvalid(m_arvalid),
    .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rlast(m_rlast), .m_axi_ruser(m_ruser),
    .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
  );

  axi_reg_slice #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
    .AW_MODE(SLICE_BYPASS), .W_MODE(SLICE_BYPASS), .B_MODE(SLICE_BYPASS),
    .AR_MODE(SLICE_BYPASS), .R_MODE(SLICE_BYPASS)
  ) dut_byp (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awvalid(s_awvalid),
    .s_axi_awready(y_s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
    .s_axi_wuser(s_wuser), .s_axi_wvalid(s_wvalid), .s_axi_wready(y_s_wready),
    .s_axi_bresp(y_s_bresp), .s_axi_buser(y_s_buser), .s_axi_bvalid(y_s_bvalid),
    .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arvalid(s_arvalid),
    .s_axi_arready(y_s_arready),
    .s_axi_rdata(y_s_rdata), .s_axi_rlast(y_s_rlast), .s_axi_ruser(y_s_ruser),
    .s_axi_rresp(y_s_rresp), .s_axi_rvalid(y_s_rvalid), .s_axi_rready(s_rready),
    .m_axi_awaddr(y_m_awaddr), .m_axi_awlen(y_m_awlen), .m_axi_awvalid(y_m_awvalid),
    .m_axi_awready(m_awready),
    .m_axi_wdata(y_m_wdata), .m_axi_wstrb(y_m_wstrb), .m_axi_wlast(y_m_wlast),
    .m_axi_wuser(y_m_wuser), .m_axi_wvalid(y_m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_buser(m_buser), .m_axi_bvalid(m_bvalid),
    .m_axi_bready(y_m_bready),
    .m_axi_araddr(y_m_araddr), .m_axi_arlen(y_m_arlen), .m_axi_arvalid(y_m_arvalid),
    .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rlast(m_rlast), .m_axi_ruser(m_ruser),
    .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(y_m_rready)
  );

  // Expected source-side ready from occupancy alone.
  function automatic logic exp_ready(slice_mode_e m, int cnt, logic out_rdy);
    case (m)
      SLICE_FULL: return cnt < 2;
      SLICE_FWD:  return (cnt == 0) || out_rdy;
      SLICE_HALF: return cnt == 0;
      default:    return out_rdy;
    endcase
  endfunction

  task automatic idle_inputs();
    s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0; m_awready = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wuser = '0; s_wvalid = 1'b0;
    m_wready = 1'b0;
    m_bresp = '0; m_buser = '0; m_bvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; m_arready = 1'b0;
    m_rdata = '0; m_rlast = 1'b0; m_ruser = '0; m_rresp = '0; m_rvalid = 1'b0;
    s_rready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    m_awready = 1'b1;
    m_bvalid  = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    n_checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_valids: got %b want 00000",
               {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid});
    end
    n_checks++;
    if ({s_awready, s_wready, s_arready, m_bready, m_rready} !== 5'b11111) begin
      n_fail++;
      $display("FAIL rst_readies: got %b want 11111",
               {s_awready, s_wready, s_arready, m_bready, m_rready});
    end
    n_checks++;
    if ({m_awaddr, m_wdata, m_araddr, s_rdata, s_bresp} !== '0) begin
      n_fail++;
      $display("FAIL rst_payload: got %h want 0", {m_awaddr, m_wdata, m_araddr, s_rdata, s_bresp});
    end
    n_checks++;
    if ({y_s_awready, y_s_bvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_bypass: got %b want 11", {y_s_awready, y_s_bvalid});
    end
  endtask

  task automatic test_aw_back_to_back();
    logic [63:0] q[$];
    logic er, ev;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      @(posedge aclk); #1;
      if (c < 8) begin
        s_awvalid = (c < 4); s_awaddr = AW'(c * 4); s_awlen = 8'd3; m_awready = 1'b1;
      end else begin
        s_awvalid = 1'($urandom_range(0, 1)); s_awaddr = AW'($urandom);
        s_awlen = 8'($urandom); m_awready = 1'($urandom_range(0, 1));
      end
      @(negedge aclk);
      ev = (q.size() > 0);
      er = exp_ready(AwM, q.size(), m_awready);
      n_checks++;
      if (s_awready !== er) begin
        n_fail++; $display("FAIL aw_ready c%0d: got %b want %b", c, s_awready, er);
      end
      n_checks++;
      if (m_awvalid !== ev) begin
        n_fail++; $display("FAIL aw_valid c%0d: got %b want %b", c, m_awvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if ({m_awaddr, m_awlen} !== q[0][AW+7:0]) begin
          n_fail++;
          $display("FAIL aw_data c%0d: got %h want %h", c, {m_awaddr, m_awlen}, q[0][AW+7:0]);
        end
      end
      if (ev && m_awready) void'(q.pop_front());
      if (s_awvalid && er) q.push_back(64'({s_awaddr, s_awlen}));
    end
  endtask

  task automatic test_w_stall();
    logic [63:0] q[$];
    logic er, ev;
    int idx = 0;
    int npop = 0;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      @(posedge aclk); #1;
      if (c < 16) begin
        s_wvalid = (idx < 8); s_wdata = DW'(idx); s_wstrb = '1;
        s_wlast = (idx == 7); s_wuser = UW'(idx); m_wready = !(c >= 2 && c <= 5);
      end else begin
        s_wvalid = 1'($urandom_range(0, 1)); s_wdata = DW'($urandom);
        s_wstrb = SW'($urandom); s_wlast = 1'($urandom); s_wuser = UW'($urandom);
        m_wready = 1'($urandom_range(0, 1));
      end
      @(negedge aclk);
      ev = (q.size() > 0);
      er = exp_ready(WM, q.size(), m_wready);
      n_checks++;
      if (s_wready !== er) begin
        n_fail++; $display("FAIL w_ready c%0d: got %b want %b", c, s_wready, er);
      end
      if (c == 3) begin
        n_checks++;
        if (s_wready !== 1'b0) begin
          n_fail++; $display("FAIL w_full_drop: got %b want 0", s_wready);
        end
      end
      n_checks++;
      if (m_wvalid !== ev) begin
        n_fail++; $display("FAIL w_valid c%0d: got %b want %b", c, m_wvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if ({m_wdata, m_wstrb, m_wlast, m_wuser} !== q[0][DW+SW+1:0]) begin
          n_fail++;
          $display("FAIL w_data c%0d: got %h want %h", c, {m_wdata, m_wstrb, m_wlast, m_wuser},
                   q[0][DW+SW+1:0]);
        end
      end
      if (ev && m_wready) begin
        void'(q.pop_front());
        if (c < 16) npop++;
      end
      if (s_wvalid && er) begin
        q.push_back(64'({s_wdata, s_wstrb, s_wlast, s_wuser}));
        if (c < 16) idx++;
      end
    end
    n_checks++;
    if (npop !== 8) begin
      n_fail++; $display("FAIL w_burst_count: got %0d want 8", npop);
    end
  endtask

  task automatic test_ar_random();
    logic [63:0] q[$];
    logic er, ev;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      @(posedge aclk); #1;
      s_arvalid = 1'($urandom_range(0, 1)); s_araddr = AW'($urandom);
      s_arlen = 8'($urandom); m_arready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      ev = (q.size() > 0);
      er = exp_ready(ArM, q.size(), m_arready);
      n_checks++;
      if (s_arready !== er) begin
        n_fail++; $display("FAIL ar_ready c%0d: got %b want %b", c, s_arready, er);
      end
      n_checks++;
      if (m_arvalid !== ev) begin
        n_fail++; $display("FAIL ar_valid c%0d: got %b want %b", c, m_arvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if ({m_araddr, m_arlen} !== q[0][AW+7:0]) begin
          n_fail++;
          $display("FAIL ar_data c%0d: got %h want %h", c, {m_araddr, m_arlen}, q[0][AW+7:0]);
        end
      end
      if (ev && m_arready) void'(q.pop_front());
      if (s_arvalid && er) q.push_back(64'({s_araddr, s_arlen}));
    end
  endtask

  task automatic test_r_half();
    logic [63:0] q[$];
    logic er, ev;
    logic prev_fire = 1'b0;
    int idx = 0;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(posedge aclk); #1;
      if (c < 12) begin
        m_rvalid = (idx < 4); m_rdata = 32'hA0 + DW'(idx); m_rlast = (idx == 3);
        m_ruser = UW'(idx); m_rresp = 2'(idx) ^ 2'b10; s_rready = 1'b1;
      end else begin
        m_rvalid = 1'($urandom_range(0, 1)); m_rdata = DW'($urandom);
        m_rlast = 1'($urandom); m_ruser = UW'($urandom); m_rresp = 2'($urandom);
        s_rready = 1'($urandom_range(0, 1));
      end
      @(negedge aclk);
      ev = (q.size() > 0);
      er = exp_ready(RM, q.size(), s_rready);
      n_checks++;
      if (m_rready !== er) begin
        n_fail++; $display("FAIL r_ready c%0d: got %b want %b", c, m_rready, er);
      end
      n_checks++;
      if (s_rvalid !== ev) begin
        n_fail++; $display("FAIL r_valid c%0d: got %b want %b", c, s_rvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if ({s_rdata, s_rlast, s_ruser, s_rresp} !== q[0][DW+3:0]) begin
          n_fail++;
          $display("FAIL r_data c%0d: got %h want %h", c, {s_rdata, s_rlast, s_ruser, s_rresp},
                   q[0][DW+3:0]);
        end
      end
      n_checks++;
      if (prev_fire && s_rvalid && s_rready) begin
        n_fail++; $display("FAIL r_half_rate c%0d: got back-to-back beats want gap", c);
      end
      prev_fire = s_rvalid && s_rready;
      if (ev && s_rready) void'(q.pop_front());
      if (m_rvalid && er) begin
        q.push_back(64'({m_rdata, m_rlast, m_ruser, m_rresp}));
        if (c < 12) idx++;
      end
    end
  endtask

  task automatic test_b_fwd();
    logic [63:0] q[$];
    logic er, ev;
    int idx = 0;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(posedge aclk); #1;
      if (c < 10) begin
        m_bvalid = (idx < 5); m_bresp = (idx == 0) ? 2'b10 : 2'(idx);
        m_buser = UW'(idx); s_bready = (c != 2);
      end else begin
        m_bvalid = 1'($urandom_range(0, 1)); m_bresp = 2'($urandom);
        m_buser = UW'($urandom); s_bready = 1'($urandom_range(0, 1));
      end
      @(negedge aclk);
      ev = (q.size() > 0);
      er = exp_ready(BM, q.size(), s_bready);
      n_checks++;
      if (m_bready !== er) begin
        n_fail++; $display("FAIL b_ready c%0d: got %b want %b", c, m_bready, er);
      end
      n_checks++;
      if (s_bvalid !== ev) begin
        n_fail++; $display("FAIL b_valid c%0d: got %b want %b", c, s_bvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if ({s_bresp, s_buser} !== q[0][UW+1:0]) begin
          n_fail++;
          $display("FAIL b_data c%0d: got %h want %h", c, {s_bresp, s_buser}, q[0][UW+1:0]);
        end
      end
      if (ev && s_bready) void'(q.pop_front());
      if (m_bvalid && er) begin
        q.push_back(64'({m_bresp, m_buser}));
        if (c < 10) idx++;
      end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge aclk); #1;
      s_awaddr = AW'($urandom); s_awlen = 8'($urandom); s_awvalid = 1'($urandom);
      m_awready = 1'($urandom);
      s_wdata = DW'($urandom); s_wstrb = SW'($urandom); s_wlast = 1'($urandom);
      s_wuser = UW'($urandom); s_wvalid = 1'($urandom); m_wready = 1'($urandom);
      m_bresp = 2'($urandom); m_buser = UW'($urandom); m_bvalid = 1'($urandom);
      s_bready = 1'($urandom);
      s_araddr = AW'($urandom); s_arlen = 8'($urandom); s_arvalid = 1'($urandom);
      m_arready = 1'($urandom);
      m_rdata = DW'($urandom); m_rlast = 1'($urandom); m_ruser = UW'($urandom);
      m_rresp = 2'($urandom); m_rvalid = 1'($urandom); s_rready = 1'($urandom);
      @(negedge aclk);
      n_checks += 5;
      if ({y_m_awaddr, y_m_awlen, y_m_awvalid, y_s_awready} !==
          {s_awaddr, s_awlen, s_awvalid, m_awready}) begin
        n_fail++; $display("FAIL byp_aw c%0d: got %h want %h", c,
                           {y_m_awaddr, y_m_awlen, y_m_awvalid, y_s_awready},
                           {s_awaddr, s_awlen, s_awvalid, m_awready});
      end
      if ({y_m_wdata, y_m_wstrb, y_m_wlast, y_m_wuser, y_m_wvalid, y_s_wready} !==
          {s_wdata, s_wstrb, s_wlast, s_wuser, s_wvalid, m_wready}) begin
        n_fail++; $display("FAIL byp_w c%0d: got %h want %h", c,
                           {y_m_wdata, y_m_wstrb, y_m_wlast, y_m_wuser, y_m_wvalid, y_s_wready},
                           {s_wdata, s_wstrb, s_wlast, s_wuser, s_wvalid, m_wready});
      end
      if ({y_s_bresp, y_s_buser, y_s_bvalid, y_m_bready} !==
          {m_bresp, m_buser, m_bvalid, s_bready}) begin
        n_fail++; $display("FAIL byp_b c%0d: got %h want %h", c,
                           {y_s_bresp, y_s_buser, y_s_bvalid, y_m_bready},
                           {m_bresp, m_buser, m_bvalid, s_bready});
      end
      if ({y_m_araddr, y_m_arlen, y_m_arvalid, y_s_arready} !==
          {s_araddr, s_arlen, s_arvalid, m_arready}) begin
        n_fail++; $display("FAIL byp_ar c%0d: got %h want %h", c,
                           {y_m_araddr, y_m_arlen, y_m_arvalid, y_s_arready},
                           {s_araddr, s_arlen, s_arvalid, m_arready});
      end
      if ({y_s_rdata, y_s_rlast, y_s_ruser, y_s_rresp, y_s_rvalid, y_m_rready} !==
          {m_rdata, m_rlast, m_ruser, m_rresp, m_rvalid, s_rready}) begin
        n_fail++; $display("FAIL byp_r c%0d: got %h want %h", c,
                           {y_s_rdata, y_s_rlast, y_s_ruser, y_s_rresp, y_s_rvalid, y_m_rready},
                           {m_rdata, m_rlast, m_ruser, m_rresp, m_rvalid, s_rready});
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] q[$];
    logic er, ev;
    do_reset();
    @(posedge aclk); #1;
    s_awvalid = 1'b1; s_awaddr = 10'h3A5; s_awlen = 8'h5A;
    s_wvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wstrb = '1;
    s_arvalid = 1'b1; s_araddr = 10'h2C3; s_arlen = 8'h11;
    m_bvalid = 1'b1; m_bresp = 2'b11; m_rvalid = 1'b1; m_rdata = 32'hCAFE0001;
    repeat (3) @(posedge aclk);
    #3;
    n_checks++;
    if ({s_awready, m_awvalid} !== 2'b01) begin
      n_fail++; $display("FAIL pre_rst_full: got %b want 01", {s_awready, m_awvalid});
    end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_valids: got %b want 00000",
               {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid});
    end
    n_checks++;
    if ({s_awready, s_wready, s_arready, m_bready, m_rready} !== 5'b11111) begin
      n_fail++;
      $display("FAIL midrst_readies: got %b want 11111",
               {s_awready, s_wready, s_arready, m_bready, m_rready});
    end
    n_checks++;
    if ({m_awaddr, m_awlen, m_wdata} !== '0) begin
      n_fail++; $display("FAIL midrst_payload: got %h want 0", {m_awaddr, m_awlen, m_wdata});
    end
    idle_inputs();
    @(posedge aclk); #1 aresetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge aclk); #1;
      s_awvalid = (c < 3); s_awaddr = AW'(32'h100 + c); s_awlen = 8'(c); m_awready = 1'b1;
      @(negedge aclk);
      ev = (q.size() > 0);
      er = exp_ready(AwM, q.size(), m_awready);
      n_checks++;
      if ({m_awvalid, s_awready} !== {ev, er}) begin
        n_fail++; $display("FAIL post_rst_aw_hs c%0d: got %b want %b", c,
                           {m_awvalid, s_awready}, {ev, er});
      end
      if (ev) begin
        n_checks++;
        if ({m_awaddr, m_awlen} !== q[0][AW+7:0]) begin
          n_fail++; $display("FAIL post_rst_aw_data c%0d: got %h want %h", c,
                             {m_awaddr, m_awlen}, q[0][AW+7:0]);
        end
      end
      n_checks++;
      if ({m_wvalid, m_arvalid, s_bvalid, s_rvalid} !== 4'b0) begin
        n_fail++; $display("FAIL post_rst_stale c%0d: got %b want 0000", c,
                           {m_wvalid, m_arvalid, s_bvalid, s_rvalid});
      end
      if (ev && m_awready) void'(q.pop_front());
      if (s_awvalid && er) q.push_back(64'({s_awaddr, s_awlen}));
    end
  endtask

  initial begin
    test_reset();
    test_aw_back_to_back();
    test_w_stall();
    test_ar_random();
    test_r_half();
    test_b_fwd();
    test_bypass();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
